pipelined_csa_adder: RTL

Parametrised, pipelined carry-select adder/subtractor. It generalises the 4-bit ripple-carry adder to arbitrary WIDTH, built from SEG-bit segments that each compute both carry-in cases in parallel. One pipeline stage per segment resolves the select, so the design closes timing at wide widths. It sits on a valid/ready stream in the datapath and sustains one operation per cycle, with full backpressure and signed-overflow reporting.

---
 rtl/pipelined_csa_adder_if.sv | 27 ++
 rtl/pipelined_csa_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipelined_csa_adder_if.sv
// Valid/ready stream bundle for the pipelined carry-select adder/subtractor.
// The master drives the operands and out_ready; the adder is the slave.
interface pipelined_csa_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor: every SEG-bit segment is pre-added for both
// carry-in values at the input, and one pipeline stage per segment picks the right half.
module pipelined_csa_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_csa_adder_if.slave bus
);
  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_badParams
    $error("pipelined_csa_adder: WIDTH must be a positive multiple of SEG");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_bb;
  logic             w_c0;
  logic             w_px;
  logic [WIDTH-1:0] w_s0;
  logic [WIDTH-1:0] w_s1;
  logic [NSEG-1:0]  w_k0;
  logic [NSEG-1:0]  w_k1;

  assign w_bb = bus.sub ? ~bus.b : bus.b;
  assign w_c0 = bus.sub | bus.cin;
  assign w_px = bus.a[WIDTH-1] ^ w_bb[WIDTH-1];

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign {w_k0[k], w_s0[k*SEG +: SEG]} = {1'b0, bus.a[k*SEG +: SEG]} + {1'b0, w_bb[k*SEG +: SEG]};
    assign {w_k1[k], w_s1[k*SEG +: SEG]} = {1'b0, bus.a[k*SEG +: SEG]} + {1'b0, w_bb[k*SEG +: SEG]}
                                           + {{SEG{1'b0}}, 1'b1};
  end

  // Stage k resolves segment k; the pending pair vectors shrink by one segment per stage.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int RW = (k + 1) * SEG;
    localparam int PN = NSEG - k;

    logic             r_valid;
    logic             r_carry;
    logic [RW-1:0]    r_res;
    logic             w_vIn;
    logic             w_cIn;
    logic             w_pxIn;
    logic [PN*SEG-1:0] w_s0In;
    logic [PN*SEG-1:0] w_s1In;
    logic [PN-1:0]    w_k0In;
    logic [PN-1:0]    w_k1In;
    logic [SEG-1:0]   w_segSel;
    logic             w_carrySel;
    logic [RW-1:0]    w_resNext;

    if (k == 0) begin : g_head
      assign w_vIn     = bus.in_valid;
      assign w_cIn     = w_c0;
      assign w_pxIn    = w_px;
      assign w_s0In    = w_s0;
      assign w_s1In    = w_s1;
      assign w_k0In    = w_k0;
      assign w_k1In    = w_k1;
      assign w_resNext = w_segSel;
    end else begin : g_body
      assign w_vIn     = g_stage[k-1].r_valid;
      assign w_cIn     = g_stage[k-1].r_carry;
      assign w_pxIn    = g_stage[k-1].g_pend.r_px;
      assign w_s0In    = g_stage[k-1].g_pend.r_s0;
      assign w_s1In    = g_stage[k-1].g_pend.r_s1;
      assign w_k0In    = g_stage[k-1].g_pend.r_k0;
      assign w_k1In    = g_stage[k-1].g_pend.r_k1;
      assign w_resNext = {w_segSel, g_stage[k-1].r_res};
    end

    assign w_segSel   = w_cIn ? w_s1In[SEG-1:0] : w_s0In[SEG-1:0];
    assign w_carrySel = w_cIn ? w_k1In[0] : w_k0In[0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_res   <= '0;
      end else if (w_advance) begin
        r_valid <= w_vIn;
        r_carry <= w_carrySel;
        r_res   <= w_resNext;
      end
    end

    if (k < NSEG - 1) begin : g_pend
      logic [(PN-1)*SEG-1:0] r_s0;
      logic [(PN-1)*SEG-1:0] r_s1;
      logic [PN-2:0]         r_k0;
      logic [PN-2:0]         r_k1;
      logic                  r_px;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s0 <= '0;
          r_s1 <= '0;
          r_k0 <= '0;
          r_k1 <= '0;
          r_px <= 1'b0;
        end else if (w_advance) begin
          r_s0 <= w_s0In[PN*SEG-1:SEG];
          r_s1 <= w_s1In[PN*SEG-1:SEG];
          r_k0 <= w_k0In[PN-1:1];
          r_k1 <= w_k1In[PN-1:1];
          r_px <= w_pxIn;
        end
      end
    end

    if (k == NSEG - 1) begin : g_tail
      logic r_ovf;

      // Carry into the MSB is recovered as sum_msb ^ a_msb ^ bb_msb.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_segSel[SEG-1] ^ w_pxIn ^ w_carrySel;
        end
      end
    end
  end

  assign w_advance     = !g_stage[NSEG-1].r_valid || bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = g_stage[NSEG-1].r_valid;
  assign bus.sum       = g_stage[NSEG-1].r_res;
  assign bus.cout      = g_stage[NSEG-1].r_carry;
  assign bus.ovf       = g_stage[NSEG-1].g_tail.r_ovf;
endmodule
